// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shared data memory for the 4-stage MIPS datapath.
//
// Owns a SIZE x SIZE-bit memory and arbitrates single-word accesses
// between port 0 (pipeline MEM stage) and port 1 (debug/loader).
// At most one access is performed per cycle. Read data returns one
// cycle after the grant. dbg_word is a combinational tap of
// mem[DBG_ADDR].
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   pN_req/we/addr/wdata         request, write enable, word address, write data
//   pN_gnt                       combinational grant (access at this posedge)
//   pN_rvalid/rdata              registered read return (rdata holds when idle)
//   dbg_word                     combinational mem[DBG_ADDR]
//
// Build option DMEM_INIT_EN:
//   defined   - reset loads mem[i] = i; conflicts resolved round-robin.
//   undefined - reset loads mem[i] = 0; port 0 always wins a conflict.
module dmem_arbiter #(
  parameter int SIZE     = 32,
  parameter int DBG_ADDR = 4,
  localparam int AW      = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [AW-1:0]   p0_addr,
  input  logic [SIZE-1:0] p0_wdata,
  output logic            p0_gnt,
  output logic            p0_rvalid,
  output logic [SIZE-1:0] p0_rdata,
  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [AW-1:0]   p1_addr,
  input  logic [SIZE-1:0] p1_wdata,
  output logic            p1_gnt,
  output logic            p1_rvalid,
  output logic [SIZE-1:0] p1_rdata,
  output logic [SIZE-1:0] dbg_word
);

  localparam logic [AW-1:0] DBG_IDX = AW'(DBG_ADDR);

  logic [SIZE-1:0] mem [SIZE];
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [SIZE-1:0] wr_data;
  logic            p0_vld_p1;
  logic            p1_vld_p1;
  logic [SIZE-1:0] p0_rdata_p1;
  logic [SIZE-1:0] p1_rdata_p1;

  // ---- stage p0: arbitration (combinational, same cycle as request) ----
`ifdef DMEM_INIT_EN
  // pri names the port preferred on the next conflict; it always points
  // at the port that lost (or did not take) the most recent grant.
  logic pri;

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (rst_n) begin
      p0_gnt = p0_req & (~p1_req | ~pri);
      p1_gnt = p1_req & (~p0_req |  pri);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri <= 1'b0;
    end else if (p0_gnt) begin
      pri <= 1'b1;
    end else if (p1_gnt) begin
      pri <= 1'b0;
    end
  end
`else
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (rst_n) begin
      p0_gnt = p0_req;
      p1_gnt = p1_req & ~p0_req;
    end
  end
`endif

  // Grants are one-hot, so the write port can be a simple mux.
  always_comb begin
    wr_en   = (p0_gnt & p0_we) | (p1_gnt & p1_we);
    wr_addr = p1_gnt ? p1_addr  : p0_addr;
    wr_data = p1_gnt ? p1_wdata : p0_wdata;
  end

  // ---- stage p1: memory update and registered read return ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) begin
`ifdef DMEM_INIT_EN
        mem[AW'(i)] <= SIZE'(i);
`else
        mem[AW'(i)] <= '0;
`endif
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A read and a write never share a cycle, so reading the pre-edge
  // array value is always the current contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_vld_p1   <= 1'b0;
      p1_vld_p1   <= 1'b0;
      p0_rdata_p1 <= '0;
      p1_rdata_p1 <= '0;
    end else begin
      p0_vld_p1 <= p0_gnt & ~p0_we;
      p1_vld_p1 <= p1_gnt & ~p1_we;
      if (p0_gnt && !p0_we) begin
        p0_rdata_p1 <= mem[p0_addr];
      end
      if (p1_gnt && !p1_we) begin
        p1_rdata_p1 <= mem[p1_addr];
      end
    end
  end

  assign p0_rvalid = p0_vld_p1;
  assign p1_rvalid = p1_vld_p1;
  assign p0_rdata  = p0_rdata_p1;
  assign p1_rdata  = p1_rdata_p1;
  assign dbg_word  = mem[DBG_IDX];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter (default parameters SIZE=32, DBG_ADDR=4).
// Works with DMEM_INIT_EN either defined or undefined.
module tb_dmem_arbiter;

  localparam int SZ  = 32;
  localparam int AWL = 5;
`ifdef DMEM_INIT_EN
  localparam bit INIT = 1'b1;
`else
  localparam bit INIT = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [AWL-1:0] p0_addr;
  logic [SZ-1:0]  p0_wdata, p0_rdata;
  logic           p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [AWL-1:0] p1_addr;
  logic [SZ-1:0]  p1_wdata, p1_rdata;
  logic [SZ-1:0]  dbg_word;

  dmem_arbiter #(.SIZE(SZ), .DBG_ADDR(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .dbg_word  (dbg_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_mem [32];
  int          m_pri;
  logic        m_vld [2];
  logic [31:0] m_rd  [2];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = INIT ? 32'(i) : 32'h0;
    m_pri    = 0;
    m_vld[0] = 1'b0;
    m_vld[1] = 1'b0;
    m_rd[0]  = 32'h0;
    m_rd[1]  = 32'h0;
  endfunction

  // Returns the port that should win this cycle, or -1 for none.
  function automatic int model_winner(input logic r0, input logic r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (r0 && r1)  return INIT ? m_pri : 0;
    return -1;
  endfunction

  function automatic void model_clock(input int win, input logic we,
                                      input logic [4:0] a, input logic [31:0] d);
    m_vld[0] = 1'b0;
    m_vld[1] = 1'b0;
    if (win < 0) return;
    if (we) m_mem[a] = d;
    else begin
      m_vld[win] = 1'b1;
      m_rd[win]  = m_mem[a];
    end
    m_pri = 1 - win;
  endfunction

  logic gs0, gs1;
  int   last_win;

  // One clock cycle: drive on negedge, check grants before posedge,
  // check registered outputs 1 time unit after posedge.
  task automatic cycle(input logic r0, input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [4:0] a1, input logic [31:0] d1);
    int win;
    @(negedge clk);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    #1;
    win = model_winner(r0, r1);
    gs0 = p0_gnt;
    gs1 = p1_gnt;
    chk1("gnt0", p0_gnt, win == 0);
    chk1("gnt1", p1_gnt, win == 1);
    @(posedge clk);
    if (win == 1) model_clock(win, w1, a1, d1);
    else          model_clock(win, w0, a0, d0);
    last_win = win;
    #1;
    chk1("rvalid0", p0_rvalid, m_vld[0]);
    chk1("rvalid1", p1_rvalid, m_vld[1]);
    chk("rdata0", p0_rdata, m_rd[0]);
    chk("rdata1", p1_rdata, m_rd[1]);
    chk("dbg_word", dbg_word, m_mem[4]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    p0_req = 1'b1;
    p1_req = 1'b1;
    #1;
    chk1("rst_gnt0", p0_gnt, 1'b0);
    chk1("rst_gnt1", p1_gnt, 1'b0);
    chk1("rst_rvalid0", p0_rvalid, 1'b0);
    chk1("rst_rvalid1", p1_rvalid, 1'b0);
    chk("rst_rdata0", p0_rdata, 32'h0);
    chk("rst_rdata1", p1_rdata, 32'h0);
    chk("rst_dbg", dbg_word, INIT ? 32'd4 : 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk1("rst_hold_gnt0", p0_gnt, 1'b0);
    chk1("rst_hold_gnt1", p1_gnt, 1'b0);
    model_reset();
    @(negedge clk);
    p0_req = 1'b0;
    p1_req = 1'b0;
    rst_n  = 1'b1;
  endtask

  typedef struct {
    logic        r0, w0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        r1, w1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        eg0, eg1, ev0, ev1;
    logic [31:0] erd0, erd1, edbg;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] i9, i4, i5, exp_rd;
    logic        e0;
    logic        r [2];
    logic        w [2];
    logic [4:0]  a [2];
    logic [31:0] d [2];

    i9 = INIT ? 32'd9 : 32'd0;
    i4 = INIT ? 32'd4 : 32'd0;
    i5 = INIT ? 32'd5 : 32'd0;

    // r0 w0 a0 d0 | r1 w1 a1 d1 | g0 g1 v0 v1 | rd0 rd1 dbg
    tbl[0] = '{1'b1,1'b0,5'd9, 32'h0,        1'b0,1'b0,5'd0,32'h0,        1'b1,1'b0,1'b1,1'b0, i9,           32'h0,        i4};
    tbl[1] = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,1'b0,1'b0, i9,           32'h0,        i4};
    tbl[2] = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,1'b1,5'd4,32'hDEADBEEF, 1'b0,1'b1,1'b0,1'b0, i9,           32'h0,        32'hDEADBEEF};
    tbl[3] = '{1'b1,1'b0,5'd4, 32'h0,        1'b0,1'b0,5'd0,32'h0,        1'b1,1'b0,1'b1,1'b0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    tbl[4] = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,1'b0,5'd4,32'h0,        1'b0,1'b1,1'b0,1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[5] = '{1'b1,1'b1,5'd31,32'h12345678, 1'b0,1'b0,5'd0,32'h0,        1'b1,1'b0,1'b0,1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[6] = '{1'b1,1'b0,5'd31,32'h0,        1'b0,1'b0,5'd0,32'h0,        1'b1,1'b0,1'b1,1'b0, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[7] = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,1'b0,5'd0,32'h0,        1'b0,1'b1,1'b0,1'b1, 32'h12345678, 32'h0,        32'hDEADBEEF};

    rst_n = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    last_win = -1;
    model_reset();

    // Directed vectors from reset
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(tbl[k].r0, tbl[k].w0, tbl[k].a0, tbl[k].d0,
            tbl[k].r1, tbl[k].w1, tbl[k].a1, tbl[k].d1);
      chk1($sformatf("vec%0d_gnt0", k), gs0, tbl[k].eg0);
      chk1($sformatf("vec%0d_gnt1", k), gs1, tbl[k].eg1);
      chk1($sformatf("vec%0d_rvalid0", k), p0_rvalid, tbl[k].ev0);
      chk1($sformatf("vec%0d_rvalid1", k), p1_rvalid, tbl[k].ev1);
      chk($sformatf("vec%0d_rdata0", k), p0_rdata, tbl[k].erd0);
      chk($sformatf("vec%0d_rdata1", k), p1_rdata, tbl[k].erd1);
      chk($sformatf("vec%0d_dbg", k), dbg_word, tbl[k].edbg);
    end

    // Conflict: both hold reads (p0 addr 1, p1 addr 2) for 5 cycles, then p0 drops
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b0, 5'd1, 32'h0, 1'b1, 1'b0, 5'd2, 32'h0);
      e0 = INIT ? (k % 2 == 0) : 1'b1;
      chk1($sformatf("conf%0d_gnt0", k), gs0, e0);
      chk1($sformatf("conf%0d_gnt1", k), gs1, ~e0);
      chk1($sformatf("conf%0d_rvalid0", k), p0_rvalid, e0);
      chk1($sformatf("conf%0d_rvalid1", k), p1_rvalid, ~e0);
      exp_rd = INIT ? (e0 ? 32'd1 : 32'd2) : 32'd0;
      if (e0) chk($sformatf("conf%0d_rdata0", k), p0_rdata, exp_rd);
      else    chk($sformatf("conf%0d_rdata1", k), p1_rdata, exp_rd);
    end
    cycle(1'b0, 1'b0, 5'd1, 32'h0, 1'b1, 1'b0, 5'd2, 32'h0);
    chk1("drop_p0_gnt1", gs1, 1'b1);
    chk1("drop_p0_rvalid1", p1_rvalid, 1'b1);
    chk("drop_p0_rdata1", p1_rdata, INIT ? 32'd2 : 32'd0);

    // Reset arriving between a read grant and its posedge
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 5'd9; p1_req = 1'b0;
    #1;
    chk1("midrd_gnt0", p0_gnt, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("midrd_gnt_forced", p0_gnt, 1'b0);
    @(posedge clk);
    #1;
    chk1("midrd_rvalid0", p0_rvalid, 1'b0);
    chk("midrd_rdata0", p0_rdata, 32'h0);
    // Release with the request already present: grant in the first cycle
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    #1;
    chk1("release_gnt0", p0_gnt, 1'b1);
    @(posedge clk);
    model_clock(0, 1'b0, 5'd9, 32'h0);
    #1;
    chk1("reissue_rvalid0", p0_rvalid, 1'b1);
    chk("reissue_rdata0", p0_rdata, i9);

    // Asynchronous clear of a pending rvalid
    @(negedge clk);
    p0_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk1("async_rvalid0", p0_rvalid, 1'b0);
    chk("async_rdata0", p0_rdata, 32'h0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // Write dropped by reset before its posedge
    @(negedge clk);
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 5'd5; p1_wdata = 32'hAAAA5555;
    #1;
    chk1("drop_wr_gnt1", p1_gnt, 1'b1);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    p1_req = 1'b0;
    model_reset();
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd5, 32'h0);
    chk("drop_wr_rdata1", p1_rdata, i5);

    // Randomized traffic; a requester not granted holds its request
    do_reset();
    for (int p = 0; p < 2; p++) begin
      r[p] = 1'b0; w[p] = 1'b0; a[p] = '0; d[p] = '0;
    end
    last_win = -1;
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!r[p] || last_win == p) begin
          r[p] = ($urandom_range(0, 3) != 0);
          w[p] = ($urandom_range(0, 2) == 0);
          a[p] = 5'($urandom_range(0, 31));
          d[p] = $urandom;
        end
      end
      cycle(r[0], w[0], a[0], d[0], r[1], w[1], a[1], d[1]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shared data-memory controller for the 4-stage MIPS datapath. Owns the SIZE×SIZE data memory and arbitrates single-word accesses between two requesters: port 0 (pipeline MEM stage, lw/sw) and port 1 (debug/loader). Each cycle at most one access is performed. Read data returns one cycle after the grant. A debug tap exposes one fixed memory word.

## Interface
Parameters:
- SIZE, 32, data width in bits and memory depth in words; AW = $clog2(SIZE) is the derived address width.
- DBG_ADDR, 4, word index driven on dbg_word.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- p0_req  input  1  port 0 access request; held until p0_gnt.
- p0_we  input  1  1 = write, 0 = read; valid with p0_req.
- p0_addr  input  AW  word address (caller passes ALU result [AW-1:0]).
- p0_wdata  input  SIZE  write data.
- p0_gnt  output  1  combinational grant; access is performed at this cycle's posedge.
- p0_rvalid  output  1  registered; high one cycle after a granted read.
- p0_rdata  output  SIZE  registered read data; holds last value when rvalid low.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- dbg_word  output  SIZE  combinational mem[DBG_ADDR].

## Operation
- State: memory array, priority pointer `pri` (0 = port 0 preferred), per-port rvalid/rdata registers.
- Grant logic (combinational):
  - Only one requesting → that port granted.
  - Both requesting → port `pri` granted.
  - No requests → no grant.
  - p0_gnt and p1_gnt are never both high.
- Granted write: mem[addr] <= wdata at posedge. rvalid stays 0.
- Granted read: rdata <= mem[addr] and rvalid <= 1 at posedge, for the granted port only. The other port's rvalid <= 0.
- Pointer update: after any granted cycle, `pri` <= the non-granted port. With no grant, `pri` holds.
- Ungranted requester: must hold req/we/addr/wdata stable. The pipeline treats ~p0_gnt & p0_req as a stall.
- Address range: AW bits index exactly SIZE words, so every address is valid and there is no wrap.
- Read-after-write:
  - A read granted the cycle after a write to the same address returns the new data.
  - dbg_word reflects a write from the posedge that performs it.

## Timing
- Reset (async assert, rst_n low):
  - p0_rvalid = p1_rvalid = 0.
  - p0_rdata = p1_rdata = 0.
  - pri = 0.
  - Memory initialised per Configuration.
  - Grants are forced 0 while rst_n is low.
- Read latency: 1 cycle, grant cycle N → rvalid/rdata valid in cycle N+1.
- Write latency: visible to any access granted in cycle N+1.
- Throughput: one access per cycle total. Back-to-back grants to the same port are allowed when only that port requests.
- Reset mid-operation:
  - Pending rvalid is cleared and in-flight read data is discarded.
  - A write whose posedge has not occurred is dropped.
  - Requesters reissue after rst_n deasserts.
- Deassertion: first grant possible in the first cycle with rst_n high.

## Configuration
- DMEM_INIT_EN:
  - Defined: reset loads mem[i] = i for all i in 0..SIZE-1, so dbg_word = DBG_ADDR after reset. Arbitration is round-robin as above.
  - Undefined: reset loads mem[i] = 0 for all i. Arbitration is fixed priority: port 0 always wins a conflict and `pri` is tied to 0.

## Test plan
- Reset check, DMEM_INIT_EN defined: pulse rst_n low mid-run → rvalids 0, rdatas 0, dbg_word = 4, no grants while low.
- Single read, DMEM_INIT_EN defined: p0 read addr 9 → p0_gnt same cycle; next cycle p0_rvalid = 1, p0_rdata = 9; following cycle p0_rvalid = 0.
- Write then read: p1 writes 0xDEADBEEF to addr 4, then p0 reads addr 4 the next cycle → p0_rdata = 0xDEADBEEF and dbg_word = 0xDEADBEEF from the write posedge.
- Round-robin, DMEM_INIT_EN defined: both ports hold read requests (p0 addr 1, p1 addr 2) for 4 cycles → grants alternate p0, p1, p0, p1; rdata values 1, 2, 1, 2 on the respective ports.
- Fixed priority, DMEM_INIT_EN undefined: both ports hold requests for 5 cycles → p0_gnt every cycle, p1_gnt never; drop p0_req → p1 granted the same cycle, p1_rdata = 0.
- Reset mid-read: p0 read granted in cycle N, rst_n asserted before posedge N+1 → p0_rvalid stays 0; after release, reissued read returns the correct value.
